// File: rtl/jfif_stream_framer.sv
// jfif_stream_framer
//   Wraps the entropy-coded byte stream from the jfpjc compressor into a complete JFIF frame.
//   Per frame it emits the fixed header from a header EBR, with the live quantisation table
//   spliced in. The buffered compressed bytes follow, then the EOI marker FF D9.
//   The output side uses ready/valid. The input side has no backpressure, and an elastic FIFO
//   absorbs the bytes that arrive while the header is still being sent.
// Ports
//   clock, reset            system clock, synchronous active-high reset
//   frame_start/frame_end   1-cycle frame delimiters from the compressor
//   in_valid, in_data       compressor byte strobe and data
//   hdr_raddr/ren/dout      header EBR read port (data valid 1 cycle after ren)
//   qt_raddr/ren/dout       quant-table EBR read port (data valid 1 cycle after ren)
//   out_valid/ready/data    output byte stream
//   out_sof, out_eof        qualify the first header byte and the final D9
//   busy                    frame in progress
//   overflow, frame_error   sticky error flags
//   frame_bytes, frame_done only with JFIF_STREAM_FRAMER_BYTE_COUNT_EN defined
// Optional feature macro: JFIF_STREAM_FRAMER_BYTE_COUNT_EN
module jfif_stream_framer #(
   parameter int unsigned HEADER_LEN = 328,
   parameter int unsigned QT_OFFSET  = 25,
   parameter int unsigned QT_LEN     = 64,
   parameter int unsigned FIFO_DEPTH = 16,
   parameter int unsigned HADDR_W    = 9
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               frame_start,
   input  logic               frame_end,
   input  logic               in_valid,
   input  logic [7:0]         in_data,
   output logic [HADDR_W-1:0] hdr_raddr,
   output logic               hdr_ren,
   input  logic [7:0]         hdr_dout,
   output logic [5:0]         qt_raddr,
   output logic               qt_ren,
   input  logic [7:0]         qt_dout,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [7:0]         out_data,
   output logic               out_sof,
   output logic               out_eof,
`ifdef JFIF_STREAM_FRAMER_BYTE_COUNT_EN
   output logic [23:0]        frame_bytes,
   output logic               frame_done,
`endif
   output logic               busy,
   output logic               overflow,
   output logic               frame_error
);
   localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
   localparam logic [HADDR_W-1:0] QT_LO    = HADDR_W'(QT_OFFSET);
   localparam logic [HADDR_W-1:0] QT_HI    = HADDR_W'(QT_OFFSET + QT_LEN);
   localparam logic [HADDR_W-1:0] HDR_LAST = HADDR_W'(HEADER_LEN - 1);
   localparam logic [PTR_W:0]     CNT_FULL = (PTR_W + 1)'(FIFO_DEPTH);

   typedef enum logic [2:0] {StIdle, StHdr, StBody, StEoiFf, StEoiD9} state_e;
   state_e state_q, state_d;

   logic [HADDR_W-1:0] idx_q, idx_d, rd_idx;
   logic               need_rd_q, need_rd_d, rd_pend_q, src_qt_q;
   logic               hvld_q, hvld_d, end_pend_q, end_pend_d;
   logic [7:0]         hbyte_q, hbyte_d;
   logic               rd_issue, rd_is_qt;

   logic [7:0]         mem_q [FIFO_DEPTH];
   logic [PTR_W-1:0]   wptr_q, rptr_q;
   logic [PTR_W:0]     cnt_q;
   logic               push_req, push, pop, full, empty;
   logic               overflow_q, frame_error_q;

   assign push_req = in_valid && (state_q != StIdle);
   assign empty    = (cnt_q == '0);
   assign full     = (cnt_q == CNT_FULL);
   assign pop      = (state_q == StBody) && !empty && out_ready;
   // A pop in the same cycle frees the slot, so push on full is still accepted.
   assign push     = push_req && (!full || pop);

   // Read index: first read of a frame uses idx_q, later reads prefetch the next byte on accept.
   assign rd_idx   = need_rd_q ? idx_q : idx_q + HADDR_W'(1);
   assign rd_is_qt = (rd_idx >= QT_LO) && (rd_idx < QT_HI);
   assign hdr_ren  = rd_issue && !rd_is_qt;
   assign qt_ren   = rd_issue && rd_is_qt;
   assign hdr_raddr = hdr_ren ? rd_idx : '0;
   assign qt_raddr  = qt_ren ? 6'(rd_idx - QT_LO) : '0;

   assign busy        = (state_q != StIdle);
   assign overflow    = overflow_q;
   assign frame_error = frame_error_q;

   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      need_rd_d  = 1'b0;
      hvld_d     = hvld_q;
      hbyte_d    = hbyte_q;
      end_pend_d = end_pend_q;
      rd_issue   = 1'b0;
      out_valid  = 1'b0;
      out_data   = 8'h00;
      out_sof    = 1'b0;
      out_eof    = 1'b0;
      if (state_q != StIdle && frame_end) end_pend_d = 1'b1;
      unique case (state_q)
         StIdle: begin
            if (frame_start) begin
               state_d    = StHdr;
               idx_d      = '0;
               need_rd_d  = 1'b1;
               hvld_d     = 1'b0;
               end_pend_d = 1'b0;
            end
         end
         StHdr: begin
            out_valid = hvld_q;
            out_data  = hbyte_q;
            out_sof   = hvld_q && (idx_q == '0);
            if (need_rd_q) rd_issue = 1'b1;
            if (rd_pend_q) begin
               hvld_d  = 1'b1;
               hbyte_d = src_qt_q ? qt_dout : hdr_dout;
            end
            if (hvld_q && out_ready) begin
               hvld_d = 1'b0;
               if (idx_q == HDR_LAST) begin
                  state_d = StBody;
               end else begin
                  idx_d    = idx_q + HADDR_W'(1);
                  rd_issue = 1'b1;
               end
            end
         end
         StBody: begin
            out_valid = !empty;
            out_data  = empty ? 8'h00 : mem_q[rptr_q];
            if (end_pend_q && empty && !push_req) state_d = StEoiFf;
         end
         StEoiFf: begin
            out_valid = 1'b1;
            out_data  = 8'hFF;
            if (out_ready) state_d = StEoiD9;
         end
         StEoiD9: begin
            out_valid = 1'b1;
            out_data  = 8'hD9;
            out_eof   = 1'b1;
            if (out_ready) begin
               state_d    = StIdle;
               end_pend_d = 1'b0;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q       <= StIdle;
         idx_q         <= '0;
         need_rd_q     <= 1'b0;
         rd_pend_q     <= 1'b0;
         src_qt_q      <= 1'b0;
         hvld_q        <= 1'b0;
         hbyte_q       <= 8'h00;
         end_pend_q    <= 1'b0;
         wptr_q        <= '0;
         rptr_q        <= '0;
         cnt_q         <= '0;
         overflow_q    <= 1'b0;
         frame_error_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         need_rd_q  <= need_rd_d;
         rd_pend_q  <= rd_issue;
         src_qt_q   <= rd_is_qt;
         hvld_q     <= hvld_d;
         hbyte_q    <= hbyte_d;
         end_pend_q <= end_pend_d;
         if (push) begin
            mem_q[wptr_q] <= in_data;
            wptr_q        <= wptr_q + PTR_W'(1);
         end
         if (pop) rptr_q <= rptr_q + PTR_W'(1);
         if (push && !pop) cnt_q <= cnt_q + (PTR_W + 1)'(1);
         else if (pop && !push) cnt_q <= cnt_q - (PTR_W + 1)'(1);
         if (push_req && !push) overflow_q <= 1'b1;
         if (frame_start && state_q != StIdle) frame_error_q <= 1'b1;
      end
   end

`ifdef JFIF_STREAM_FRAMER_BYTE_COUNT_EN
   // Registered so frame_done coincides with the final count on frame_bytes.
   always_ff @(posedge clock) begin
      if (reset) begin
         frame_bytes <= '0;
         frame_done  <= 1'b0;
      end else begin
         frame_done <= (state_q == StEoiD9) && out_ready;
         if (state_q == StIdle && frame_start) frame_bytes <= '0;
         else if (out_valid && out_ready) frame_bytes <= frame_bytes + 24'd1;
      end
   end
`endif
endmodule
